// File: rtl/data_sram_responder_if.sv
// Data-side SRAM port between the CPU core (master) and the responder (slave).
// One request per cycle; rdata carries the answer to the previous cycle's request.
interface data_sram_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Data-side memory responder: byte-writable synchronous RAM plus a small
// configuration window (LED, seven-seg number, switches, free-running timer).
// Reads are read-first and registered: the answer appears one cycle after the request.
module data_sram_responder #(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] CONF_HI = 16'h1faf,
  parameter int          LED_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  data_sram_responder_if.slave bus,
  input  logic [7:0]        switch_in,
  output logic [LED_W-1:0]  led_out,
  output logic [31:0]       num_out
);

  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_NUM    = 16'hf010;
  localparam logic [15:0] OFF_SWITCH = 16'hf020;
  localparam logic [15:0] OFF_TIMER  = 16'he000;

  // Replace the byte lanes selected by be with the corresponding bytes of new_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]       mem [0:(2**RAM_AW)-1];
  logic [31:0]       rdata_r;
  logic [LED_W-1:0]  led_r;
  logic [31:0]       num_r;
  logic [31:0]       timer_r;

  logic              sel_conf_s;
  logic [15:0]       off_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic              wr_s;
  logic              ram_wr_s;
  logic [31:0]       led_ext_s;
  logic [31:0]       rd_mux_s;
  logic              unused_addr_s;

  assign sel_conf_s    = (bus.addr[31:16] == CONF_HI);
  assign off_s         = bus.addr[15:0];
  assign ram_idx_s     = bus.addr[RAM_AW+1:2];
  assign wr_s          = bus.en && (bus.wen != 4'b0000);
  assign ram_wr_s      = wr_s && !sel_conf_s;
  assign led_ext_s     = 32'(led_r);
  // Word-offset bits and RAM-aliasing upper bits play no part in decode.
  assign unused_addr_s = ^{bus.addr[1:0], bus.addr[31:RAM_AW+2]};

  // Read-value selection from the pre-edge state (gives read-first behaviour).
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    if (sel_conf_s) begin
      case (off_s)
        OFF_LED:    rd_mux_s = led_ext_s;
        OFF_NUM:    rd_mux_s = num_r;
        OFF_SWITCH: rd_mux_s = {24'h00_0000, switch_in};
        OFF_TIMER:  rd_mux_s = timer_r;
        default:    rd_mux_s = 32'h0000_0000;
      endcase
    end else begin
      rd_mux_s = mem[ram_idx_s];
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wen[i]) begin
          mem[ram_idx_s][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read data; holds while the port is idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_r <= 32'h0000_0000;
    end else if (bus.en) begin
      rdata_r <= rd_mux_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // LED and NUM registers with byte-lane writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_r <= '0;
      num_r <= 32'h0000_0000;
    end else if (wr_s && sel_conf_s && (off_s == OFF_LED)) begin
      led_r <= LED_W'(merge_bytes(led_ext_s, bus.wdata, bus.wen));
    end else if (wr_s && sel_conf_s && (off_s == OFF_NUM)) begin
      num_r <= merge_bytes(num_r, bus.wdata, bus.wen);
    end else begin
      led_r <= led_r;
      num_r <= num_r;
    end
  end

  // Free-running timer; a write replaces the selected lanes and skips that edge's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_r <= 32'h0000_0000;
    end else if (wr_s && sel_conf_s && (off_s == OFF_TIMER)) begin
      timer_r <= merge_bytes(timer_r, bus.wdata, bus.wen);
    end else begin
      timer_r <= timer_r + 32'h0000_0001;
    end
  end

  assign bus.rdata = rdata_r;
  assign led_out   = led_r;
  assign num_out   = num_r;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed vector table, hand-written
// timer/reset sequences and randomized traffic against a behavioural model.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;

  data_sram_responder_if bus_if ();

  data_sram_responder #(.RAM_AW(14), .CONF_HI(16'h1faf), .LED_W(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if),
    .switch_in (switch_in),
    .led_out   (led_out),
    .num_out   (num_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [31:0] ram_m [int];
  logic [31:0] m_rdata;
  bit          m_rd_known;
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic [31:0] exp_num;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_rdata    = 32'h0;
    m_rd_known = 1'b1;
    m_led      = 16'h0;
    m_num      = 32'h0;
    m_timer    = 32'h0;
  endtask

  // One rising edge of the model, applying the request present at that edge.
  task automatic model_edge(input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bit          conf;
    logic [15:0] off;
    int          idx;
    bit          tm_wr;
    logic [31:0] tmp;
    conf  = (addr[31:16] == 16'h1faf);
    off   = addr[15:0];
    idx   = int'((addr / 32'd4) % 32'd16384);
    tm_wr = 1'b0;
    if (en) begin
      m_rd_known = 1'b1;
      if (conf) begin
        case (off)
          16'hf000: m_rdata = {16'h0, m_led};
          16'hf010: m_rdata = m_num;
          16'hf020: m_rdata = {24'h0, switch_in};
          16'he000: m_rdata = m_timer;
          default:  m_rdata = 32'h0;
        endcase
      end else if (ram_m.exists(idx)) begin
        m_rdata = ram_m[idx];
      end else begin
        m_rd_known = 1'b0;
      end
      if (wen != 4'h0) begin
        if (conf) begin
          case (off)
            16'hf000: begin tmp = merge({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
            16'hf010: m_num = merge(m_num, wdata, wen);
            16'he000: begin m_timer = merge(m_timer, wdata, wen); tm_wr = 1'b1; end
            default: ;
          endcase
        end else begin
          tmp = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
          ram_m[idx] = merge(tmp, wdata, wen);
        end
      end
    end
    if (!tm_wr) m_timer = m_timer + 32'd1;
  endtask

  // Drive one request, clock it, advance the model and compare outputs.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input string tag);
    @(negedge clk);
    bus_if.en    = en;
    bus_if.wen   = wen;
    bus_if.addr  = addr;
    bus_if.wdata = wdata;
    @(posedge clk);
    model_edge(en, wen, addr, wdata);
    #1;
    if (m_rd_known) chk({tag, " rdata"}, bus_if.rdata, m_rdata);
    chk({tag, " led"}, {16'h0, led_out}, {16'h0, m_led});
    chk({tag, " num"}, num_out, m_num);
  endtask

  logic [31:0] rnd_addrs [10];

  initial begin
    resetn       = 1'b0;
    switch_in    = 8'h5a;
    bus_if.en    = 1'b0;
    bus_if.wen   = 4'h0;
    bus_if.addr  = 32'h0;
    bus_if.wdata = 32'h0;
    model_reset();

    //          en    wen    addr          wdata         chk   exp_rdata     exp_led   exp_num
    vecs[0]  = '{1'b1, 4'hf, 32'h0000_0200, 32'h0000_0000, 1'b0, 32'h0,        16'h0,    32'h0};
    vecs[1]  = '{1'b1, 4'hf, 32'h0000_0204, 32'h0000_0005, 1'b0, 32'h0,        16'h0,    32'h0};
    vecs[2]  = '{1'b1, 4'hf, 32'h0000_0100, 32'h1122_3344, 1'b0, 32'h0,        16'h0,    32'h0};
    vecs[3]  = '{1'b1, 4'h2, 32'h0000_0100, 32'h0000_aa00, 1'b1, 32'h1122_3344, 16'h0,   32'h0};
    vecs[4]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h1122_aa44, 16'h0,   32'h0};
    vecs[5]  = '{1'b1, 4'hf, 32'h0000_0200, 32'hdead_beef, 1'b1, 32'h0000_0000, 16'h0,   32'h0};
    vecs[6]  = '{1'b1, 4'h0, 32'h0000_0200, 32'h0000_0000, 1'b1, 32'hdead_beef, 16'h0,   32'h0};
    vecs[7]  = '{1'b1, 4'h0, 32'h0000_0204, 32'h0000_0000, 1'b1, 32'h0000_0005, 16'h0,   32'h0};
    vecs[8]  = '{1'b0, 4'hf, 32'h0000_0200, 32'h7777_7777, 1'b1, 32'h0000_0005, 16'h0,   32'h0};
    vecs[9]  = '{1'b1, 4'hf, 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0,        16'h0,    32'h0};
    vecs[10] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 16'h0,   32'h0};
    vecs[11] = '{1'b1, 4'hf, 32'h1faf_f000, 32'h0000_ffff, 1'b1, 32'h0000_0000, 16'hffff, 32'h0};
    vecs[12] = '{1'b1, 4'hf, 32'h1faf_f010, 32'h1234_5678, 1'b1, 32'h0000_0000, 16'hffff, 32'h1234_5678};
    vecs[13] = '{1'b1, 4'h0, 32'h1faf_f000, 32'h0000_0000, 1'b1, 32'h0000_ffff, 16'hffff, 32'h1234_5678};
    vecs[14] = '{1'b1, 4'h1, 32'h1faf_f010, 32'h0000_00ab, 1'b1, 32'h1234_5678, 16'hffff, 32'h1234_56ab};
    vecs[15] = '{1'b1, 4'h0, 32'h1faf_f030, 32'h0000_0000, 1'b1, 32'h0000_0000, 16'hffff, 32'h1234_56ab};
    vecs[16] = '{1'b1, 4'hf, 32'h1faf_f030, 32'hffff_ffff, 1'b1, 32'h0000_0000, 16'hffff, 32'h1234_56ab};
    vecs[17] = '{1'b1, 4'hf, 32'h1faf_f020, 32'h0000_1234, 1'b1, 32'h0000_005a, 16'hffff, 32'h1234_56ab};
    vecs[18] = '{1'b1, 4'h0, 32'h1faf_f020, 32'h0000_0000, 1'b1, 32'h0000_005a, 16'hffff, 32'h1234_56ab};

    // Power-on reset, released between edges
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    chk("por rdata", bus_if.rdata, 32'h0);
    chk("por led", {16'h0, led_out}, 32'h0);
    chk("por num", num_out, 32'h0);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
      if (vecs[i].chk) chk($sformatf("vec%0d exp_rdata", i), bus_if.rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d exp_led", i), {16'h0, led_out}, {16'h0, vecs[i].exp_led});
      chk($sformatf("vec%0d exp_num", i), num_out, vecs[i].exp_num);
    end

    // Timer write then wrap through 0
    step(1'b1, 4'hf, 32'h1faf_e000, 32'hffff_fffe, "tmr wr");
    step(1'b1, 4'h0, 32'h1faf_e000, 32'h0, "tmr rd0");
    chk("tmr rd0 const", bus_if.rdata, 32'hffff_fffe);
    step(1'b1, 4'h0, 32'h1faf_e000, 32'h0, "tmr rd1");
    chk("tmr rd1 const", bus_if.rdata, 32'hffff_ffff);
    step(1'b1, 4'h0, 32'h1faf_e000, 32'h0, "tmr rd2");
    chk("tmr rd2 const", bus_if.rdata, 32'h0000_0000);

    // Randomized traffic over known RAM words (including an alias) and the config window
    rnd_addrs = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0204, 32'h0000_0000, 32'h4000_0100,
                  32'h1faf_f000, 32'h1faf_f010, 32'h1faf_f020, 32'h1faf_f030, 32'h1faf_e000};
    for (int i = 0; i < 300; i++) begin
      logic [3:0] w;
      switch_in = 8'($urandom);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step(($urandom_range(0, 3) != 0), w, rnd_addrs[$urandom_range(0, 9)], $urandom,
           $sformatf("rnd%0d", i));
    end

    // Mid-run reset: registers clear, RAM is kept, timer restarts at 0
    @(negedge clk);
    resetn    = 1'b0;
    bus_if.en = 1'b0;
    #1;
    chk("mrst async rdata", bus_if.rdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    model_reset();
    chk("mrst rdata", bus_if.rdata, 32'h0);
    chk("mrst led", {16'h0, led_out}, 32'h0);
    chk("mrst num", num_out, 32'h0);
    step(1'b1, 4'h0, 32'h1faf_e000, 32'h0, "mrst tmr0");
    chk("mrst tmr0 const", bus_if.rdata, 32'h0);
    step(1'b1, 4'h0, 32'h1faf_e000, 32'h0, "mrst tmr1");
    chk("mrst tmr1 const", bus_if.rdata, 32'h1);
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0, "mrst ram keep");
    step(1'b0, 4'h0, 32'h0, 32'h0, "idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
